// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for a 5-stage pipeline with a multi-cycle divide unit in E.
//
// Ports:
//   i_clk, i_reset            clock, asynchronous active-low reset
//   i_instr_{D,E,M,W}         instruction word held by each stage
//   i_rd_wren_{E,M,W}         destination-register write enable per stage
//   i_pc_sel_E                taken branch/jump resolved in E
//   i_mem_ready               data memory ready for the load/store in M
//   o_stall_{F,D,E,M}         stage keeps its register
//   o_flush_{D,E,M,W}         stage register loads a bubble
//   o_fwd_a_E, o_fwd_b_E      E operand source: 00 regfile, 10 M result, 01 W result
//   o_mc_busy                 divide unit is holding E
//   o_stall_cnt, o_flush_cnt  saturating counts of F-stall cycles and branch flushes
module hazard_ctrl_mc #(
  parameter int unsigned FWD_EN = 1,
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_instr_D,
  input  logic [31:0]      i_instr_E,
  input  logic [31:0]      i_instr_M,
  input  logic [31:0]      i_instr_W,
  input  logic             i_rd_wren_E,
  input  logic             i_rd_wren_M,
  input  logic             i_rd_wren_W,
  input  logic             i_pc_sel_E,
  input  logic             i_mem_ready,
  output logic             o_stall_F,
  output logic             o_stall_D,
  output logic             o_stall_E,
  output logic             o_stall_M,
  output logic             o_flush_D,
  output logic             o_flush_E,
  output logic             o_flush_M,
  output logic             o_flush_W,
  output logic [1:0]       o_fwd_a_E,
  output logic [1:0]       o_fwd_b_E,
  output logic             o_mc_busy,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam logic       FwdOn      = (FWD_EN != 0);
  localparam logic       MultiCycle = (MC_LAT > 1);
  localparam logic [3:0] McLast     = 4'(MC_LAT - 1);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpReg   = 7'b0110011;
  localparam logic [6:0] F7MulDv = 7'b0000001;

  // Field decode
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic [6:0] op_E, op_M;

  assign rs1_D = i_instr_D[19:15];
  assign rs2_D = i_instr_D[24:20];
  assign rs1_E = i_instr_E[19:15];
  assign rs2_E = i_instr_E[24:20];
  assign rd_E  = i_instr_E[11:7];
  assign rd_M  = i_instr_M[11:7];
  assign rd_W  = i_instr_W[11:7];
  assign op_E  = i_instr_E[6:0];
  assign op_M  = i_instr_M[6:0];

  logic unused_instr_bits;
  assign unused_instr_bits = ^{i_instr_D[31:25], i_instr_D[14:0], i_instr_E[13:12],
                               i_instr_M[31:12], i_instr_W[31:12], i_instr_W[6:0]};

  // x0 never creates a dependency.
  function automatic logic hit(input logic [4:0] rs, input logic [4:0] rd, input logic wren);
    return wren && (rs == rd) && (rs != 5'd0);
  endfunction

  // Hazard detection
  logic div_E, ld_stall, raw_stall, mem_stall, mc_stall;

  // DIV/DIVU/REM/REMU: M-extension R-type with funct3[2] set.
  assign div_E = (op_E == OpReg) && (i_instr_E[31:25] == F7MulDv) && i_instr_E[14];

  assign ld_stall = FwdOn && (op_E == OpLoad) &&
                    (hit(rs1_D, rd_E, i_rd_wren_E) || hit(rs2_D, rd_E, i_rd_wren_E));

  // Without forwarding, D waits until the producer reaches W; the register file
  // writes through so W itself needs no stall.
  assign raw_stall = !FwdOn &&
                     (hit(rs1_D, rd_E, i_rd_wren_E) || hit(rs2_D, rd_E, i_rd_wren_E) ||
                      hit(rs1_D, rd_M, i_rd_wren_M) || hit(rs2_D, rd_M, i_rd_wren_M));

  assign mem_stall = ((op_M == OpLoad) || (op_M == OpStore)) && !i_mem_ready;

  // Multi-cycle FSM
  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e     state_q, state_d;
  logic [3:0] mc_cnt_q, mc_cnt_d;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= StIdle;
      mc_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  // A memory stall freezes the whole pipe, so the divide sequence freezes too.
  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    if (!mem_stall) begin
      unique case (state_q)
        StIdle: begin
          if (div_E && MultiCycle) begin
            state_d  = StBusy;
            mc_cnt_d = 4'd1;
          end
        end
        StBusy: begin
          if (mc_cnt_q == McLast) begin
            state_d  = StIdle;
            mc_cnt_d = 4'd0;
          end else begin
            mc_cnt_d = mc_cnt_q + 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // The first divide cycle stalls straight from IDLE; the last cycle in BUSY releases E.
  always_comb begin
    mc_stall = 1'b0;
    unique case (state_q)
      StIdle:  mc_stall = div_E && MultiCycle;
      StBusy:  mc_stall = (mc_cnt_q != McLast);
      default: mc_stall = 1'b0;
    endcase
  end

  assign o_mc_busy = i_reset && mc_stall;

  // Stall / flush arbitration, highest priority first. A taken branch simply waits
  // while E is held: i_pc_sel_E stays high until the branch can leave E.
  always_comb begin
    o_stall_F = 1'b0;
    o_stall_D = 1'b0;
    o_stall_E = 1'b0;
    o_stall_M = 1'b0;
    o_flush_D = 1'b0;
    o_flush_E = 1'b0;
    o_flush_M = 1'b0;
    o_flush_W = 1'b0;
    if (i_reset) begin
      if (mem_stall) begin
        o_stall_F = 1'b1;
        o_stall_D = 1'b1;
        o_stall_E = 1'b1;
        o_stall_M = 1'b1;
        o_flush_W = 1'b1;
      end else if (mc_stall) begin
        o_stall_F = 1'b1;
        o_stall_D = 1'b1;
        o_stall_E = 1'b1;
        o_flush_M = 1'b1;
      end else if (ld_stall || raw_stall) begin
        o_stall_F = 1'b1;
        o_stall_D = 1'b1;
        o_flush_E = 1'b1;
      end else if (i_pc_sel_E) begin
        o_flush_D = 1'b1;
        o_flush_E = 1'b1;
      end
    end
  end

  // Forwarding; M is newer than W so it wins.
  always_comb begin
    o_fwd_a_E = 2'b00;
    o_fwd_b_E = 2'b00;
    if (i_reset && FwdOn) begin
      if (hit(rs1_E, rd_M, i_rd_wren_M)) begin
        o_fwd_a_E = 2'b10;
      end else if (hit(rs1_E, rd_W, i_rd_wren_W)) begin
        o_fwd_a_E = 2'b01;
      end
      if (hit(rs2_E, rd_M, i_rd_wren_M)) begin
        o_fwd_b_E = 2'b10;
      end else if (hit(rs2_E, rd_W, i_rd_wren_W)) begin
        o_fwd_b_E = 2'b01;
      end
    end
  end

  // Performance counters; flush_D is only ever raised by the branch case.
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (o_stall_F && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (o_flush_D && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
module tb_hazard_ctrl_mc;

  localparam int LAT_A = 4;
  localparam int LAT_B = 1;
  localparam int MAX_A = 65535;
  localparam int MAX_B = 15;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] iD, iE, iM, iW;
  logic        wrE, wrM, wrW, pc, rdy;

  logic        sFa, sDa, sEa, sMa, fDa, fEa, fMa, fWa, busy_a;
  logic        sFb, sDb, sEb, sMb, fDb, fEb, fMb, fWb, busy_b;
  logic [1:0]  fwa_a, fwb_a, fwa_b, fwb_b;
  logic [15:0] scnt_a, fcnt_a;
  logic [3:0]  scnt_b, fcnt_b;

  hazard_ctrl_mc #(.FWD_EN(1), .MC_LAT(LAT_A), .CNT_W(16)) u_dut_a (
    .i_clk(clk), .i_reset(rst_n),
    .i_instr_D(iD), .i_instr_E(iE), .i_instr_M(iM), .i_instr_W(iW),
    .i_rd_wren_E(wrE), .i_rd_wren_M(wrM), .i_rd_wren_W(wrW),
    .i_pc_sel_E(pc), .i_mem_ready(rdy),
    .o_stall_F(sFa), .o_stall_D(sDa), .o_stall_E(sEa), .o_stall_M(sMa),
    .o_flush_D(fDa), .o_flush_E(fEa), .o_flush_M(fMa), .o_flush_W(fWa),
    .o_fwd_a_E(fwa_a), .o_fwd_b_E(fwb_a), .o_mc_busy(busy_a),
    .o_stall_cnt(scnt_a), .o_flush_cnt(fcnt_a)
  );

  hazard_ctrl_mc #(.FWD_EN(0), .MC_LAT(LAT_B), .CNT_W(4)) u_dut_b (
    .i_clk(clk), .i_reset(rst_n),
    .i_instr_D(iD), .i_instr_E(iE), .i_instr_M(iM), .i_instr_W(iW),
    .i_rd_wren_E(wrE), .i_rd_wren_M(wrM), .i_rd_wren_W(wrW),
    .i_pc_sel_E(pc), .i_mem_ready(rdy),
    .o_stall_F(sFb), .o_stall_D(sDb), .o_stall_E(sEb), .o_stall_M(sMb),
    .o_flush_D(fDb), .o_flush_E(fEb), .o_flush_M(fMb), .o_flush_W(fWb),
    .o_fwd_a_E(fwa_b), .o_fwd_b_E(fwb_b), .o_mc_busy(busy_b),
    .o_stall_cnt(scnt_b), .o_flush_cnt(fcnt_b)
  );

  // Packed view: {stall F,D,E,M, flush D,E,M,W, fwd_a, fwd_b, busy}
  logic [12:0] got_a, got_b, exp_a, exp_b;
  assign got_a = {sFa, sDa, sEa, sMa, fDa, fEa, fMa, fWa, fwa_a, fwb_a, busy_a};
  assign got_b = {sFb, sDb, sEb, sMb, fDb, fEb, fMb, fWb, fwa_b, fwb_b, busy_b};

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // occ_* = cycles the current divide has already spent in E (0 = none in progress).
  int occ_a, occ_b, sc_a, sc_b, fc_a, fc_b;

  function automatic bit hits(input logic [4:0] rs, input logic [4:0] rd, input logic wr);
    return wr && (rs == rd) && (rs != 5'd0);
  endfunction

  function automatic logic [1:0] src(input logic [4:0] rs, input logic [31:0] m,
                                     input logic [31:0] w, input logic wm, input logic ww);
    if (hits(rs, m[11:7], wm)) return 2'b10;
    if (hits(rs, w[11:7], ww)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [12:0] model(input bit fwd, input int lat, input int occ,
      input logic rst, input logic [31:0] d, input logic [31:0] e, input logic [31:0] m,
      input logic [31:0] w, input logic we, input logic wm, input logic ww,
      input logic br, input logic ready);
    logic [12:0] r;
    bit is_div, busy, memw, lduse, raw, dep_e, dep_m;
    r = '0;
    if (!rst) return r;
    is_div = (e[6:0] == 7'h33) && (e[31:25] == 7'h01) && e[14];
    busy   = (occ == 0) ? (is_div && lat > 1) : (occ < lat - 1);
    memw   = ((m[6:0] == 7'h03) || (m[6:0] == 7'h23)) && !ready;
    dep_e  = hits(d[19:15], e[11:7], we) || hits(d[24:20], e[11:7], we);
    dep_m  = hits(d[19:15], m[11:7], wm) || hits(d[24:20], m[11:7], wm);
    lduse  = fwd && (e[6:0] == 7'h03) && dep_e;
    raw    = !fwd && (dep_e || dep_m);
    if (fwd) begin
      r[4:3] = src(e[19:15], m, w, wm, ww);
      r[2:1] = src(e[24:20], m, w, wm, ww);
    end
    r[0] = busy;
    if (memw)              r[12:5] = 8'b1111_0001;
    else if (busy)         r[12:5] = 8'b1110_0010;
    else if (lduse || raw) r[12:5] = 8'b1100_0100;
    else if (br)           r[12:5] = 8'b0000_1100;
    return r;
  endfunction

  assign exp_a = model(1'b1, LAT_A, occ_a, rst_n, iD, iE, iM, iW, wrE, wrM, wrW, pc, rdy);
  assign exp_b = model(1'b0, LAT_B, occ_b, rst_n, iD, iE, iM, iW, wrE, wrM, wrW, pc, rdy);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_a <= 0; occ_b <= 0; sc_a <= 0; sc_b <= 0; fc_a <= 0; fc_b <= 0;
    end else begin
      if (exp_a[12] && sc_a < MAX_A) sc_a <= sc_a + 1;
      if (exp_b[12] && sc_b < MAX_B) sc_b <= sc_b + 1;
      if (exp_a[8] && fc_a < MAX_A) fc_a <= fc_a + 1;
      if (exp_b[8] && fc_b < MAX_B) fc_b <= fc_b + 1;
      if (!exp_a[5]) begin
        if (occ_a == 0) begin
          if (exp_a[0]) occ_a <= 1;
        end else begin
          occ_a <= (occ_a == LAT_A - 1) ? 0 : occ_a + 1;
        end
      end
      if (!exp_b[5]) begin
        if (occ_b == 0) begin
          if (exp_b[0]) occ_b <= 1;
        end else begin
          occ_b <= (occ_b == LAT_B - 1) ? 0 : occ_b + 1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [6:0] ops [5];
    ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33; ops[3] = 7'h63; ops[4] = 7'h13;
    return enc(($urandom_range(0, 1) != 0) ? 7'h01 : 7'h00, 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
               5'($urandom_range(0, 3)), ops[$urandom_range(0, 4)]);
  endfunction

  task automatic drive(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m,
      input logic [31:0] w, input logic we, input logic wm, input logic ww,
      input logic br, input logic ready);
    iD = d; iE = e; iM = m; iW = w; wrE = we; wrM = wm; wrW = ww; pc = br; rdy = ready;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(NOP, NOP, NOP, NOP, 0, 0, 0, 0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    // Worst case inputs: divide in E, memory stall, taken branch
    drive(NOP, enc(7'h01, 2, 1, 3'b100, 7, 7'h33), enc(0, 0, 1, 2, 5, 7'h03), NOP,
          1, 1, 0, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (got_a !== 13'd0) begin errors++; $display("FAIL reset_out_a: got %b want 0", got_a); end
    checks++;
    if (got_b !== 13'd0) begin errors++; $display("FAIL reset_out_b: got %b want 0", got_b); end
    checks++;
    if (scnt_a !== 16'd0 || fcnt_a !== 16'd0) begin
      errors++; $display("FAIL reset_cnt_a: got %0d/%0d want 0/0", scnt_a, fcnt_a);
    end
    @(negedge clk);
    drive(NOP, NOP, NOP, NOP, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
  endtask

  task automatic test_forward();
    logic [31:0] e_m [4];
    logic [31:0] e_e [4];
    logic [31:0] e_w [4];
    logic        e_wm [4];
    logic        e_ww [4];
    logic [3:0]  want [4];
    e_m[0] = enc(0, 2, 1, 0, 5, 7'h33); e_e[0] = enc(7'h20, 7, 5, 0, 6, 7'h33);
    e_w[0] = NOP; e_wm[0] = 1; e_ww[0] = 0; want[0] = 4'b10_00;
    e_m[1] = enc(0, 2, 1, 0, 0, 7'h33); e_e[1] = enc(7'h20, 7, 0, 0, 6, 7'h33);
    e_w[1] = NOP; e_wm[1] = 1; e_ww[1] = 0; want[1] = 4'b00_00;
    e_m[2] = enc(0, 2, 1, 0, 5, 7'h33); e_e[2] = enc(0, 5, 5, 0, 6, 7'h33);
    e_w[2] = enc(0, 2, 1, 0, 5, 7'h33); e_wm[2] = 1; e_ww[2] = 1; want[2] = 4'b10_10;
    e_m[3] = enc(0, 2, 1, 0, 5, 7'h33); e_e[3] = enc(0, 7, 5, 0, 6, 7'h33);
    e_w[3] = enc(0, 2, 1, 0, 7, 7'h33); e_wm[3] = 0; e_ww[3] = 1; want[3] = 4'b00_01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(NOP, e_e[i], e_m[i], e_w[i], 1, e_wm[i], e_ww[i], 0, 1);
      #1;
      checks++;
      if (got_a[4:1] !== want[i]) begin
        errors++; $display("FAIL fwd_case%0d_a: got %b want %b", i, got_a[4:1], want[i]);
      end
      checks++;
      if (got_b[4:1] !== 4'b0000) begin
        errors++; $display("FAIL fwd_case%0d_b: got %b want 0000", i, got_b[4:1]);
      end
      checks++;
      if (got_a !== exp_a) begin
        errors++; $display("FAIL fwd_model%0d_a: got %b want %b", i, got_a, exp_a);
      end
    end
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk);
    drive(enc(0, 1, 3, 0, 4, 7'h33), enc(0, 0, 2, 3'b010, 3, 7'h03), NOP, NOP, 1, 0, 0, 0, 1);
    #1;
    checks++;
    if (got_a !== 13'b1100_0100_0000_0) begin
      errors++; $display("FAIL load_use_a: got %b want 1100010000000", got_a);
    end
    checks++;
    if (got_b !== exp_b) begin errors++; $display("FAIL load_use_b: got %b want %b", got_b, exp_b); end
    @(negedge clk);
    drive(enc(0, 1, 3, 0, 4, 7'h33), NOP, enc(0, 0, 2, 3'b010, 3, 7'h03), NOP, 0, 1, 0, 0, 1);
    #1;
    checks++;
    if (got_a !== 13'd0) begin errors++; $display("FAIL load_use_release_a: got %b want 0", got_a); end
    checks++;
    if (got_b !== exp_b) begin errors++; $display("FAIL raw_m_b: got %b want %b", got_b, exp_b); end
    @(negedge clk);
    drive(NOP, NOP, NOP, NOP, 0, 0, 0, 0, 1);
    #1;
    checks++;
    if (scnt_a !== 16'd1) begin errors++; $display("FAIL load_use_cnt: got %0d want 1", scnt_a); end
  endtask

  task automatic test_div();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(NOP, enc(7'h01, 2, 1, 3'b100, 7, 7'h33), NOP, NOP, 1, 0, 0, 0, 1);
      #1;
      checks++;
      if (i < 3 && got_a !== 13'b1110_0010_0000_1) begin
        errors++; $display("FAIL div_busy%0d: got %b want 1110001000001", i, got_a);
      end else if (i == 3 && got_a !== 13'd0) begin
        errors++; $display("FAIL div_release: got %b want 0", got_a);
      end
      checks++;
      if (got_b !== 13'd0) begin errors++; $display("FAIL div_lat1_b%0d: got %b want 0", i, got_b); end
    end
    @(negedge clk);
    drive(NOP, NOP, NOP, NOP, 0, 0, 0, 0, 1);
    #1;
    checks++;
    if (scnt_a !== 16'd3 || got_a !== 13'd0) begin
      errors++; $display("FAIL div_cnt: got cnt=%0d out=%b want 3/0", scnt_a, got_a);
    end
  endtask

  task automatic test_branch_mem();
    logic [31:0] beq, sw;
    beq = enc(0, 2, 1, 3'b000, 5'd8, 7'h63);
    sw  = enc(0, 2, 1, 3'b010, 5'd4, 7'h23);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(NOP, beq, sw, NOP, 0, 0, 0, 1, (i == 2));
      #1;
      checks++;
      if (i < 2 && got_a !== 13'b1111_0001_0000_0) begin
        errors++; $display("FAIL br_mem_stall%0d: got %b want 1111000100000", i, got_a);
      end else if (i == 2 && got_a !== 13'b0000_1100_0000_0) begin
        errors++; $display("FAIL br_after_mem: got %b want 0000110000000", got_a);
      end
      checks++;
      if (got_b !== exp_b) begin errors++; $display("FAIL br_mem_b%0d: got %b want %b", i, got_b, exp_b); end
    end
    @(negedge clk);
    drive(NOP, NOP, NOP, NOP, 0, 0, 0, 0, 1);
    #1;
    checks++;
    if (fcnt_a !== 16'd1 || scnt_a !== 16'd2) begin
      errors++; $display("FAIL br_cnt_a: got f=%0d s=%0d want 1/2", fcnt_a, scnt_a);
    end
    checks++;
    if (fcnt_b !== 4'd1 || scnt_b !== 4'd2) begin
      errors++; $display("FAIL br_cnt_b: got f=%0d s=%0d want 1/2", fcnt_b, scnt_b);
    end
  endtask

  task automatic test_reset_busy();
    logic [31:0] dv;
    dv = enc(7'h01, 2, 1, 3'b110, 7, 7'h33);
    do_reset();
    repeat (2) begin
      @(negedge clk);
      drive(NOP, dv, NOP, NOP, 1, 0, 0, 0, 1);
    end
    @(negedge clk);
    #1;
    checks++;
    if (scnt_a !== 16'd2 || got_a[0] !== 1'b1) begin
      errors++; $display("FAIL busy_pre_reset: got cnt=%0d busy=%b want 2/1", scnt_a, got_a[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (got_a !== 13'd0 || scnt_a !== 16'd0 || fcnt_a !== 16'd0) begin
      errors++; $display("FAIL busy_reset: got out=%b cnt=%0d want 0/0", got_a, scnt_a);
    end
    @(negedge clk);
    drive(NOP, NOP, NOP, NOP, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (got_a !== 13'd0) begin errors++; $display("FAIL idle_after_reset%0d: got %b want 0", i, got_a); end
      @(negedge clk);
    end
    drive(NOP, dv, NOP, NOP, 1, 0, 0, 0, 1);
    #1;
    checks++;
    if (got_a !== 13'b1110_0010_0000_1) begin
      errors++; $display("FAIL div_restart: got %b want 1110001000001", got_a);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    repeat (20) begin
      @(negedge clk);
      drive(enc(0, 1, 5, 0, 4, 7'h33), enc(0, 0, 2, 3'b010, 5, 7'h03), NOP, NOP, 1, 0, 0, 0, 1);
      #1;
      checks++;
      if (got_b !== exp_b || got_a !== exp_a) begin
        errors++; $display("FAIL sat_stall: got %b/%b want %b/%b", got_a, got_b, exp_a, exp_b);
      end
    end
    @(negedge clk);
    drive(NOP, NOP, NOP, NOP, 0, 0, 0, 0, 1);
    #1;
    checks++;
    if (scnt_b !== 4'd15) begin errors++; $display("FAIL sat_cnt_b: got %0d want 15", scnt_b); end
    checks++;
    if (scnt_a !== 16'd20) begin errors++; $display("FAIL sat_cnt_a: got %0d want 20", scnt_a); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      drive(rnd_instr(), rnd_instr(), rnd_instr(), rnd_instr(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
      #1;
      checks++;
      if (got_a !== exp_a) begin errors++; $display("FAIL rnd%0d_a: got %b want %b", i, got_a, exp_a); end
      checks++;
      if (got_b !== exp_b) begin errors++; $display("FAIL rnd%0d_b: got %b want %b", i, got_b, exp_b); end
      checks++;
      if (int'(scnt_a) != sc_a || int'(fcnt_a) != fc_a) begin
        errors++;
        $display("FAIL rnd%0d_cnt_a: got %0d/%0d want %0d/%0d", i, scnt_a, fcnt_a, sc_a, fc_a);
      end
      checks++;
      if (int'(scnt_b) != sc_b || int'(fcnt_b) != fc_b) begin
        errors++;
        $display("FAIL rnd%0d_cnt_b: got %0d/%0d want %0d/%0d", i, scnt_b, fcnt_b, sc_b, fc_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_div();
    test_branch_mem();
    test_reset_busy();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
